dmem_sequencer: RTL and testbench

- Top-level sequencer that owns the single-port data memory and shares it, one phase at a time, between three users:
  - an external byte loader (image in),
  - the downsampling processor (run),
  - an external byte unloader (result out).
- Orders the phases LOAD -> START -> RUN -> DUMP -> DONE.
- Generates the processor start pulse and detects completion from the processor status.

---
 rtl/dmem_sequencer.sv | 174 +++++++++++++++++
 tb/tb_dmem_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sequencer.sv
// dmem_sequencer: owns the single-port data memory and lends it, one phase at a
// time, to the byte loader, the downsampling processor and the byte unloader.
module dmem_sequencer #(
  parameter int ADDR_W    = 19,
  parameter int IMG_WORDS = 65536,
  parameter int OUT_BASE  = 65536,
  parameter int OUT_WORDS = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic              proc_start,
  input  logic              proc_status,
  input  logic [1:0]        proc_mem,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [7:0]        proc_wdata,
  output logic [7:0]        proc_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [7:0]        dmem_wdata,
  output logic              dmem_we,
  input  logic [7:0]        dmem_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    RUN       = 3'd3,
    DUMP_RD   = 3'd4,
    DUMP_WAIT = 3'd5,
    DUMP_TX   = 3'd6,
    DONE      = 3'd7
  } state_t;

  // Terminal compares use the last index so the counters never need an extra bit.
  localparam logic [ADDR_W-1:0] LC_LAST    = ADDR_W'(IMG_WORDS - 1);
  localparam logic [ADDR_W-1:0] OC_LAST    = ADDR_W'(OUT_WORDS - 1);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] lc_r;
  logic [ADDR_W-1:0] oc_r;
  logic              seen_low_r;
  logic [7:0]        tx_data_r;
  logic              job_go_s;
  logic              load_fire_s;
  logic              run_exit_s;
  logic              tx_fire_s;

  assign job_go_s    = go && ((state_r == IDLE) || (state_r == DONE));
  assign load_fire_s = (state_r == LOAD) && load_valid;
  // A status of 1 only counts after a 0 was seen, so a stale 1 cannot end RUN.
  assign run_exit_s  = (state_r == RUN) && proc_status && seen_low_r;
  assign tx_fire_s   = (state_r == DUMP_TX) && tx_ready;

  assign proc_rdata = dmem_rdata;
  assign tx_data    = tx_data_r;

  // Phase state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Phase ordering.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:      if (job_go_s) state_s = LOAD; else state_s = IDLE;
      LOAD:      if (load_fire_s && (lc_r == LC_LAST)) state_s = START; else state_s = LOAD;
      START:     state_s = RUN;
      RUN:       if (run_exit_s) state_s = DUMP_RD; else state_s = RUN;
      DUMP_RD:   state_s = DUMP_WAIT;
      DUMP_WAIT: state_s = DUMP_TX;
      DUMP_TX: begin
        if (tx_fire_s) begin
          if (oc_r == OC_LAST) state_s = DONE;
          else state_s = DUMP_RD;
        end else begin
          state_s = DUMP_TX;
        end
      end
      DONE:      if (job_go_s) state_s = LOAD; else state_s = DONE;
      default:   state_s = IDLE;
    endcase
  end

  // Load/output counters, status history and the unloader byte register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lc_r       <= ADDR_ZERO;
      oc_r       <= ADDR_ZERO;
      seen_low_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      if (job_go_s) begin
        lc_r <= ADDR_ZERO;
      end else if (load_fire_s) begin
        lc_r <= lc_r + ADDR_ONE;
      end

      if (run_exit_s) begin
        oc_r <= ADDR_ZERO;
      end else if (tx_fire_s && (oc_r != OC_LAST)) begin
        oc_r <= oc_r + ADDR_ONE;
      end

      if (state_r == START) begin
        seen_low_r <= 1'b0;
      end else if ((state_r == RUN) && !proc_status) begin
        seen_low_r <= 1'b1;
      end

      if (state_r == DUMP_WAIT) begin
        tx_data_r <= dmem_rdata;
      end
    end
  end

  // Per-phase memory mux and handshake outputs.
  always_comb begin
    load_ready = 1'b0;
    proc_start = 1'b0;
    dmem_addr  = ADDR_ZERO;
    dmem_wdata = 8'h00;
    dmem_we    = 1'b0;
    tx_valid   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_r)
      IDLE: busy = 1'b0;
      LOAD: begin
        load_ready = 1'b1;
        dmem_addr  = lc_r;
        if (load_valid) begin
          dmem_we    = 1'b1;
          dmem_wdata = load_data;
        end else begin
          dmem_we    = 1'b0;
          dmem_wdata = 8'h00;
        end
      end
      START: proc_start = 1'b1;
      RUN: begin
        dmem_addr  = proc_addr;
        dmem_wdata = proc_wdata;
        dmem_we    = (proc_mem == 2'b10);
      end
      DUMP_RD:   dmem_addr = OUT_BASE_A + oc_r;
      DUMP_WAIT: dmem_addr = OUT_BASE_A + oc_r;
      DUMP_TX:   tx_valid  = 1'b1;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dmem_sequencer.sv
// Scoreboard bench for dmem_sequencer with a small behavioural data memory;
// expected writes and unloader bytes are queued when stimulus is driven.
module tb_dmem_sequencer;
  localparam int ADDR_W    = 19;
  localparam int IMG_WORDS = 4;
  localparam int OUT_BASE  = 8;
  localparam int OUT_WORDS = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              go = 1'b0;
  logic              load_valid = 1'b0;
  logic [7:0]        load_data = 8'h00;
  logic              load_ready;
  logic              proc_start;
  logic              proc_status = 1'b0;
  logic [1:0]        proc_mem = 2'b00;
  logic [ADDR_W-1:0] proc_addr = '0;
  logic [7:0]        proc_wdata = 8'h00;
  logic [7:0]        proc_rdata;
  logic [ADDR_W-1:0] dmem_addr;
  logic [7:0]        dmem_wdata;
  logic              dmem_we;
  logic [7:0]        dmem_rdata = 8'h00;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready = 1'b0;
  logic              busy;
  logic              done;

  logic [7:0] mem [0:15];
  wr_t        exp_wr_q[$];
  logic [7:0] tx_exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         handshakes = 0;

  dmem_sequencer #(
    .ADDR_W(ADDR_W), .IMG_WORDS(IMG_WORDS), .OUT_BASE(OUT_BASE), .OUT_WORDS(OUT_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .proc_start(proc_start), .proc_status(proc_status), .proc_mem(proc_mem),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Single-port memory: write-enable at the edge, read data one cycle after the address.
  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr[3:0]] <= dmem_wdata;
    dmem_rdata <= mem[dmem_addr[3:0]];
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({load_ready, proc_start, dmem_we, tx_valid, busy, done} !== 6'b0) begin
      bad++;
      $display("FAIL reset_hold: ctl=%b want 000000", {load_ready, proc_start, dmem_we, tx_valid, busy, done});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    total++;
    if ({load_ready, proc_start, dmem_we, tx_valid, busy, done} !== 6'b0 ||
        dmem_addr !== '0 || dmem_wdata !== 8'h00 || tx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_release: ctl=%b addr=%0h wdata=%h tx=%h want all 0",
               {load_ready, proc_start, dmem_we, tx_valid, busy, done}, dmem_addr, dmem_wdata, tx_data);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      load_valid = c[0]; load_data = 8'h5A;
      proc_mem = 2'b10; proc_addr = 19'd3; proc_wdata = 8'h77;
      #1;
      total++;
      if (dmem_we !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b0) begin
        bad++;
        $display("FAIL idle_ignore: we=%b busy=%b ready=%b want 0 0 0", dmem_we, busy, load_ready);
      end
    end
    load_valid = 1'b0; proc_mem = 2'b00;
  endtask

  task automatic test_load(input bit gaps);
    wr_t e;
    int  accepted;
    @(negedge clk);
    go = 1'b1; proc_status = 1'b1; load_valid = 1'b0;
    proc_mem = 2'b10; proc_addr = 19'd5; proc_wdata = 8'hEE;
    #1;
    total++;
    if (dmem_we !== 1'b0 || load_ready !== 1'b0) begin
      bad++;
      $display("FAIL go_cycle: we=%b ready=%b want 0 0", dmem_we, load_ready);
    end
    accepted = 0;
    for (int c = 0; c < 16 && accepted < IMG_WORDS; c++) begin
      @(negedge clk);
      go = 1'b0;
      load_valid = gaps ? ~c[0] : 1'b1;
      load_data = 8'hA0 + 8'(accepted);
      if (load_valid) exp_wr_q.push_back('{ADDR_W'(accepted), load_data});
      #1;
      total++;
      if (load_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL load_ready: ready=%b done=%b busy=%b want 1 0 1", load_ready, done, busy);
      end
      total++;
      if (load_valid) begin
        e = exp_wr_q.pop_front();
        accepted++;
        if (dmem_we !== 1'b1 || dmem_addr !== e.addr || dmem_wdata !== e.data) begin
          bad++;
          $display("FAIL load_write: we=%b addr=%0h data=%h want 1 %0h %h", dmem_we, dmem_addr, dmem_wdata, e.addr, e.data);
        end
      end else if (dmem_we !== 1'b0) begin
        bad++;
        $display("FAIL load_gap: we=%b want 0", dmem_we);
      end
    end
    @(negedge clk); load_valid = 1'b1; load_data = 8'hFF; #1;
    total++;
    if (load_ready !== 1'b0 || proc_start !== 1'b1 || dmem_we !== 1'b0) begin
      bad++;
      $display("FAIL start: ready=%b start=%b we=%b want 0 1 0", load_ready, proc_start, dmem_we);
    end
    @(negedge clk); load_valid = 1'b0; proc_mem = 2'b00; #1;
    total++;
    if (proc_start !== 1'b0 || dmem_addr !== proc_addr || dmem_we !== 1'b0) begin
      bad++;
      $display("FAIL start_pulse: start=%b addr=%0h we=%b want 0 %0h 0", proc_start, dmem_addr, dmem_we, proc_addr);
    end
    total++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== 32'hA0A1A2A3 || mem[5] === 8'hEE) begin
      bad++;
      $display("FAIL load_mem: got %h%h%h%h m5=%h want a0a1a2a3, m5 untouched", mem[0], mem[1], mem[2], mem[3], mem[5]);
    end
  endtask

  task automatic test_run(input logic [7:0] d0, input logic [7:0] d1);
    logic [1:0]        pm;
    logic [ADDR_W-1:0] pa;
    logic [7:0]        pw;
    wr_t               e;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      case (c)
        0:       begin pm = 2'b10; pa = 19'd8; pw = d0; end
        1:       begin pm = 2'b10; pa = 19'd9; pw = d1; end
        3:       begin pm = 2'b01; pa = 19'd8; pw = 8'h00; end
        default: begin pm = 2'b00; pa = 19'd3; pw = 8'hC3; end
      endcase
      go = (c == 2); proc_status = 1'b1;
      proc_mem = pm; proc_addr = pa; proc_wdata = pw;
      if (pm == 2'b10) begin
        exp_wr_q.push_back('{pa, pw});
        tx_exp_q.push_back(pw);
      end
      #1;
      total++;
      if (dmem_addr !== pa || tx_valid !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL run_stale: addr=%0h txv=%b busy=%b want %0h 0 1", dmem_addr, tx_valid, busy, pa);
      end
      total++;
      if (pm == 2'b10) begin
        e = exp_wr_q.pop_front();
        if (dmem_we !== 1'b1 || dmem_addr !== e.addr || dmem_wdata !== e.data) begin
          bad++;
          $display("FAIL run_write: we=%b addr=%0h data=%h want 1 %0h %h", dmem_we, dmem_addr, dmem_wdata, e.addr, e.data);
        end
      end else if (dmem_we !== 1'b0) begin
        bad++;
        $display("FAIL run_nowrite: we=%b want 0", dmem_we);
      end
      if (c == 4) begin
        total++;
        if (proc_rdata !== d0) begin
          bad++;
          $display("FAIL run_read: rdata=%h want %h", proc_rdata, d0);
        end
      end
    end
    @(negedge clk); go = 1'b0; proc_mem = 2'b00; proc_addr = 19'd2; proc_status = 1'b0; #1;
    total++;
    if (dmem_addr !== 19'd2 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL run_low: addr=%0h txv=%b want 2 0", dmem_addr, tx_valid);
    end
    @(negedge clk); proc_status = 1'b1; #1;
    total++;
    if (dmem_addr !== 19'd2) begin
      bad++;
      $display("FAIL run_high: addr=%0h want 2", dmem_addr);
    end
    @(negedge clk); proc_mem = 2'b10; proc_addr = 19'd3; proc_wdata = 8'hBB; #1;
    total++;
    if (dmem_addr !== ADDR_W'(OUT_BASE) || dmem_we !== 1'b0 || dmem_wdata !== 8'h00 || busy !== 1'b1) begin
      bad++;
      $display("FAIL dump_rd: addr=%0h we=%b wdata=%h busy=%b want %0h 0 00 1", dmem_addr, dmem_we, dmem_wdata, busy, OUT_BASE);
    end
  endtask

  task automatic test_dump(input int stall);
    bit         found;
    logic [7:0] e;
    handshakes = 0;
    for (int b = 0; b < OUT_WORDS; b++) begin
      found = 1'b0;
      for (int w = 0; w < 8 && !found; w++) begin
        @(negedge clk); tx_ready = 1'b0; #1;
        if (tx_valid === 1'b1) found = 1'b1;
      end
      total++;
      if (!found) begin
        bad++;
        $display("FAIL dump_wait: tx_valid=0 want 1 for byte %0d", b);
      end else begin
        for (int s = 0; s < stall; s++) begin
          if (s > 0) begin @(negedge clk); #1; end
          total++;
          if (tx_valid !== 1'b1 || tx_data !== tx_exp_q[0] || dmem_we !== 1'b0) begin
            bad++;
            $display("FAIL dump_hold: txv=%b data=%h we=%b want 1 %h 0", tx_valid, tx_data, dmem_we, tx_exp_q[0]);
          end
        end
        @(negedge clk); tx_ready = 1'b1; #1;
        e = tx_exp_q.pop_front();
        if (tx_valid === 1'b1) handshakes++;
        total++;
        if (tx_valid !== 1'b1 || tx_data !== e) begin
          bad++;
          $display("FAIL dump_data: txv=%b data=%h want 1 %h", tx_valid, tx_data, e);
        end
        @(negedge clk); tx_ready = 1'b0; #1;
        total++;
        if (tx_valid !== 1'b0) begin
          bad++;
          $display("FAIL dump_drop: txv=%b want 0", tx_valid);
        end
        total++;
        if (b < OUT_WORDS - 1) begin
          if (dmem_addr !== ADDR_W'(OUT_BASE + b + 1)) begin
            bad++;
            $display("FAIL dump_next: addr=%0h want %0h", dmem_addr, OUT_BASE + b + 1);
          end
        end else if (done !== 1'b1 || busy !== 1'b0) begin
          bad++;
          $display("FAIL dump_done: done=%b busy=%b want 1 0", done, busy);
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); tx_ready = 1'b1; #1;
      if (tx_valid === 1'b1) handshakes++;
      total++;
      if (done !== 1'b1 || dmem_we !== 1'b0) begin
        bad++;
        $display("FAIL done_hold: done=%b we=%b want 1 0", done, dmem_we);
      end
    end
    tx_ready = 1'b0; proc_mem = 2'b00;
    total++;
    if (handshakes !== OUT_WORDS) begin
      bad++;
      $display("FAIL handshake_count: got %0d want %0d", handshakes, OUT_WORDS);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    test_load(1'b0);
    test_run(8'h77, 8'h88);
    found = 1'b0;
    for (int w = 0; w < 8 && !found; w++) begin
      @(negedge clk); tx_ready = 1'b0; #1;
      if (tx_valid === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL abort_reach: tx_valid=0 want 1");
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({tx_valid, busy, done, load_ready, dmem_we} !== 5'b0 || tx_data !== 8'h00 || dmem_addr !== '0) begin
      bad++;
      $display("FAIL abort_async: ctl=%b tx=%h addr=%0h want 0 00 0", {tx_valid, busy, done, load_ready, dmem_we}, tx_data, dmem_addr);
    end
    tx_exp_q.delete();
    exp_wr_q.delete();
    @(negedge clk); rst_n = 1'b1; proc_mem = 2'b00; #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: busy=%b done=%b txv=%b want 0 0 0", busy, done, tx_valid);
    end
  endtask

  task automatic test_back_to_back();
    test_load(1'b1);
    test_run(8'h33, 8'h44);
    test_dump(2);
  endtask

  initial begin
    test_reset();
    test_load(1'b1);
    test_run(8'h55, 8'h66);
    test_dump(5);
    test_reset_mid();
    test_load(1'b0);
    test_run(8'h11, 8'h22);
    test_dump(0);
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
